// File: rtl/chacha20_pkg.sv
// ---------------------------------------------------------------------------
// chacha20_pkg
// Shared definitions for the chacha20 core-sharing logic.
//   state_t        : arbiter FSM states (IDLE, RELOAD, REQ, WAIT)
//   owner_t        : requester encoding; OWNER_INVALID marks "no key loaded"
//   KEY_W..BLK_W   : key, nonce, block-counter and keystream block widths
// ---------------------------------------------------------------------------
package chacha20_pkg;

    localparam int KEY_W   = 256;
    localparam int NONCE_W = 96;
    localparam int CTR_W   = 32;
    localparam int BLK_W   = 512;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        REQ    = 2'd2,
        WAIT   = 2'd3
    } state_t;

    typedef logic [1:0] owner_t;

    localparam owner_t OWNER_TX      = 2'd0;
    localparam owner_t OWNER_RX      = 2'd1;
    localparam owner_t OWNER_INVALID = 2'b11;

endpackage

// File: rtl/chacha20_core_arbiter.sv
// ---------------------------------------------------------------------------
// chacha20_core_arbiter
// Shares one chacha20 core between two stream requesters (0 = TX, 1 = RX).
// Requests are latched and granted round-robin; the granted requester's
// key/nonce/counter are held towards the core for the whole grant, the core
// key is re-loaded whenever the owner changes, and the returned keystream
// block is handed back with a one-cycle strobe. A watchdog aborts a grant
// whose core never completes.
//
// Ports
//   i_aclk, i_areset        clock, asynchronous active-high reset
//   i_req[1:0]              keystream request pulse per requester
//   i_key_reload[1:0]       requester key/nonce changed (pulse)
//   i_key0/1, i_nonce0/1,
//   i_counter0/1            per-requester key material and block counter
//   o_busy[1:0]             request pending or in service, per requester
//   o_keystream             last delivered block (shared)
//   o_keystream_valid[1:0]  delivery strobe to the owner
//   o_core_req              core keystream request
//   o_core_key_reload       core key reload
//   o_core_key/nonce/counter muxed key material held for the grant
//   i_core_busy             core busy
//   i_core_keystream        core keystream block
//   i_core_valid            core keystream valid
//   o_error                 sticky watchdog timeout; cleared by any i_key_reload
// ---------------------------------------------------------------------------
module chacha20_core_arbiter
    import chacha20_pkg::*;
#(
    parameter int unsigned C_TIMEOUT = 1024
) (
    input  logic               i_aclk,
    input  logic               i_areset,
    input  logic [1:0]         i_req,
    input  logic [1:0]         i_key_reload,
    input  logic [KEY_W-1:0]   i_key0,
    input  logic [KEY_W-1:0]   i_key1,
    input  logic [NONCE_W-1:0] i_nonce0,
    input  logic [NONCE_W-1:0] i_nonce1,
    input  logic [CTR_W-1:0]   i_counter0,
    input  logic [CTR_W-1:0]   i_counter1,
    output logic [1:0]         o_busy,
    output logic [BLK_W-1:0]   o_keystream,
    output logic [1:0]         o_keystream_valid,
    output logic               o_core_req,
    output logic               o_core_key_reload,
    output logic [KEY_W-1:0]   o_core_key,
    output logic [NONCE_W-1:0] o_core_nonce,
    output logic [CTR_W-1:0]   o_core_counter,
    input  logic               i_core_busy,
    input  logic [BLK_W-1:0]   i_core_keystream,
    input  logic               i_core_valid,
    output logic               o_error
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(C_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  pending;
    logic        rr_last;
    logic        owner_q;
    owner_t      loaded_owner;
    logic [15:0] wait_cnt;

    logic        grant;
    logic        grant_owner;
    logic [1:0]  grant_mask;
    logic        need_reload;
    logic        core_done;
    logic        timeout_hit;

    // Next-state and core handshake decode. A grant is only ever made from
    // IDLE; when both requesters are pending the one that was not served
    // last wins. A key reload pulse arriving in the grant cycle itself also
    // forces a RELOAD, since the fresh key is what gets latched. In WAIT a
    // core completion takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        state_nxt         = state;
        grant             = 1'b0;
        grant_owner       = 1'b0;
        grant_mask        = 2'b00;
        need_reload       = 1'b0;
        core_done         = 1'b0;
        timeout_hit       = 1'b0;
        o_core_req        = 1'b0;
        o_core_key_reload = 1'b0;
        case (state)
            IDLE: begin
                if (pending != 2'b00) begin
                    grant       = 1'b1;
                    grant_owner = (pending == 2'b11) ? ~rr_last : pending[1];
                    grant_mask  = grant_owner ? 2'b10 : 2'b01;
                    need_reload = (loaded_owner != {1'b0, grant_owner}) ||
                                  i_key_reload[grant_owner];
                    state_nxt   = need_reload ? RELOAD : REQ;
                end
            end
            RELOAD: begin
                o_core_key_reload = 1'b1;
                state_nxt         = REQ;
            end
            REQ: begin
                if (!i_core_busy) begin
                    o_core_req = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                if (i_core_valid) begin
                    core_done = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending request flags. A new request always wins over the grant clear,
    // so a request during its own service queues exactly one follow-on;
    // repeated pulses while already pending simply merge.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            pending <= 2'b00;
        end else begin
            pending <= (pending & ~grant_mask) | i_req;
        end
    end

    // Grant-time capture: owner, round-robin history and the key material
    // presented to the core stay frozen for the whole grant, even if the
    // requester changes its inputs meanwhile.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            rr_last        <= 1'b1;
            owner_q        <= 1'b0;
            o_core_key     <= '0;
            o_core_nonce   <= '0;
            o_core_counter <= '0;
        end else if (grant) begin
            rr_last        <= grant_owner;
            owner_q        <= grant_owner;
            o_core_key     <= grant_owner ? i_key1     : i_key0;
            o_core_nonce   <= grant_owner ? i_nonce1   : i_nonce0;
            o_core_counter <= grant_owner ? i_counter1 : i_counter0;
        end
    end

    // Tracks whose key the core currently holds. A reload pulse from that
    // requester invalidates it; if the pulse lands during the RELOAD cycle
    // itself the key just loaded is already stale, so it is marked invalid.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            loaded_owner <= OWNER_INVALID;
        end else if (state == RELOAD) begin
            loaded_owner <= i_key_reload[owner_q] ? OWNER_INVALID : {1'b0, owner_q};
        end else if (loaded_owner != OWNER_INVALID && i_key_reload[loaded_owner[0]]) begin
            loaded_owner <= OWNER_INVALID;
        end
    end

    // Watchdog counter: held at zero outside WAIT so every WAIT entry starts
    // from zero, and saturates rather than wrapping.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    // Keystream delivery: the block is registered and the owner's strobe
    // follows the core's valid by one cycle. The block register keeps the
    // last delivery until the next one.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            o_keystream       <= '0;
            o_keystream_valid <= 2'b00;
        end else begin
            o_keystream_valid <= 2'b00;
            if (core_done) begin
                o_keystream       <= i_core_keystream;
                o_keystream_valid <= owner_q ? 2'b10 : 2'b01;
            end
        end
    end

    // Sticky timeout flag. Any key reload clears it, but a timeout in the
    // same cycle takes precedence so the event is never lost.
    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            o_error <= 1'b0;
        end else if (timeout_hit) begin
            o_error <= 1'b1;
        end else if (i_key_reload != 2'b00) begin
            o_error <= 1'b0;
        end
    end

    assign o_busy = pending | ((state != IDLE) ? (owner_q ? 2'b10 : 2'b01) : 2'b00);

endmodule
